// File: rtl/core_types_pkg.sv
// rtl/core_types_pkg.sv - shared sizing constants and types for the memory dependence predictor table
package core_types_pkg;

    localparam int ASID_WIDTH             = 9;
    localparam int MDPT_ENTRIES_PER_BLOCK = 8;
    localparam int MDPT_INDEX_WIDTH       = 9;
    localparam int MDPT_INFO_WIDTH        = 2;

    localparam int MDPT_SETS       = 1 << MDPT_INDEX_WIDTH;
    localparam int MDPT_SLOT_WIDTH = $clog2(MDPT_ENTRIES_PER_BLOCK);
    // Halfword slots: bit 0 is dropped, slot bits sit just above it, block index above those
    localparam int MDPT_SLOT_LSB   = 1;
    localparam int MDPT_INDEX_LSB  = MDPT_SLOT_LSB + MDPT_SLOT_WIDTH;
    localparam int MDPT_INDEX_MSB  = MDPT_INDEX_LSB + MDPT_INDEX_WIDTH - 1;

    typedef logic [MDPT_INFO_WIDTH-1:0]        mdpt_ctr_t;
    typedef logic [MDPT_INDEX_WIDTH-1:0]       mdpt_idx_t;
    typedef logic [MDPT_SLOT_WIDTH-1:0]        mdpt_slot_t;
    typedef logic [MDPT_ENTRIES_PER_BLOCK-1:0] mdpt_pred_t;

    localparam mdpt_ctr_t MDPT_CTR_ZERO = '0;
    localparam mdpt_ctr_t MDPT_CTR_ONE  = mdpt_ctr_t'(1);
    localparam mdpt_ctr_t MDPT_CTR_MAX  = '1;

endpackage

// File: rtl/mdpt_sat_counter.sv
// rtl/mdpt_sat_counter.sv - next-value logic for one saturating up/down confidence counter
module mdpt_sat_counter
    import core_types_pkg::*;
(
    input  mdpt_ctr_t count,
    input  logic      inc,
    output mdpt_ctr_t count_next
);

    always_comb begin
        count_next = count;
        if (inc) begin
            if (count != MDPT_CTR_MAX) begin
                count_next = count + MDPT_CTR_ONE;
            end
        end else begin
            if (count != MDPT_CTR_ZERO) begin
                count_next = count - MDPT_CTR_ONE;
            end
        end
    end

endmodule

// File: rtl/mdpt.sv
// rtl/mdpt.sv - tagless memory dependence prediction table, 1-cycle lookup; MDPT_ASID_HASH_EN folds ASID into the index
module mdpt
    import core_types_pkg::*;
(
    input  logic                              CLK,
    input  logic                              nRST,
    input  logic                              valid_REQ,
    input  logic [31:0]                       full_PC_REQ,
    input  logic [ASID_WIDTH-1:0]             ASID_REQ,
    output logic [MDPT_ENTRIES_PER_BLOCK-1:0] dep_pred_by_instr_RESP,
    input  logic                              dep_update0_valid,
    input  logic [31:0]                       dep_update0_start_full_PC,
    input  logic [ASID_WIDTH-1:0]             dep_update0_ASID,
    input  logic                              dep_update0_dep_truth
);

    mdpt_ctr_t  table_q [MDPT_SETS][MDPT_ENTRIES_PER_BLOCK];
    mdpt_pred_t resp_q;

    mdpt_idx_t  req_idx;
    mdpt_idx_t  upd_idx;
    mdpt_slot_t upd_slot;
    mdpt_ctr_t  upd_count;
    mdpt_ctr_t  upd_count_next;
    mdpt_pred_t req_pred;

`ifdef MDPT_ASID_HASH_EN
    assign req_idx = full_PC_REQ[MDPT_INDEX_MSB:MDPT_INDEX_LSB] ^ mdpt_idx_t'(ASID_REQ);
    assign upd_idx = dep_update0_start_full_PC[MDPT_INDEX_MSB:MDPT_INDEX_LSB]
                     ^ mdpt_idx_t'(dep_update0_ASID);
`else
    assign req_idx = full_PC_REQ[MDPT_INDEX_MSB:MDPT_INDEX_LSB];
    assign upd_idx = dep_update0_start_full_PC[MDPT_INDEX_MSB:MDPT_INDEX_LSB];

    logic unused_asid_bits;
    assign unused_asid_bits = ^{ASID_REQ, dep_update0_ASID};
`endif

    assign upd_slot = dep_update0_start_full_PC[MDPT_SLOT_LSB +: MDPT_SLOT_WIDTH];

    // Tagless table: high PC bits alias freely; lookups read the whole block so slot bits are not needed
    logic unused_pc_bits;
    assign unused_pc_bits = ^{full_PC_REQ[31:MDPT_INDEX_MSB+1], full_PC_REQ[MDPT_INDEX_LSB-1:0],
                              dep_update0_start_full_PC[31:MDPT_INDEX_MSB+1],
                              dep_update0_start_full_PC[MDPT_SLOT_LSB-1:0]};

    assign upd_count = table_q[upd_idx][upd_slot];

    mdpt_sat_counter u_sat_counter (
        .count      (upd_count),
        .inc        (dep_update0_dep_truth),
        .count_next (upd_count_next)
    );

    always_comb begin
        req_pred = '0;
        for (int e = 0; e < MDPT_ENTRIES_PER_BLOCK; e++) begin
            req_pred[e] = table_q[req_idx][e][MDPT_INFO_WIDTH-1];
        end
    end

    // Lookup samples the table before this edge's update lands, so a same-set update is not visible
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            for (int s = 0; s < MDPT_SETS; s++) begin
                for (int e = 0; e < MDPT_ENTRIES_PER_BLOCK; e++) begin
                    table_q[s][e] <= MDPT_CTR_ZERO;
                end
            end
            resp_q <= '0;
        end else begin
            if (dep_update0_valid) begin
                table_q[upd_idx][upd_slot] <= upd_count_next;
            end
            resp_q <= valid_REQ ? req_pred : '0;
        end
    end

    assign dep_pred_by_instr_RESP = resp_q;

endmodule

// File: tb/tb_mdpt.sv
// tb/tb_mdpt.sv - directed vector table plus randomized run against a table-level reference model
module tb_mdpt;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        valid_REQ;
    logic [31:0] full_PC_REQ;
    logic [8:0]  ASID_REQ;
    logic [7:0]  dep_pred_by_instr_RESP;
    logic        dep_update0_valid;
    logic [31:0] dep_update0_start_full_PC;
    logic [8:0]  dep_update0_ASID;
    logic        dep_update0_dep_truth;

    always #5 CLK = ~CLK;

    mdpt dut (
        .CLK                       (CLK),
        .nRST                      (nRST),
        .valid_REQ                 (valid_REQ),
        .full_PC_REQ               (full_PC_REQ),
        .ASID_REQ                  (ASID_REQ),
        .dep_pred_by_instr_RESP    (dep_pred_by_instr_RESP),
        .dep_update0_valid         (dep_update0_valid),
        .dep_update0_start_full_PC (dep_update0_start_full_PC),
        .dep_update0_ASID          (dep_update0_ASID),
        .dep_update0_dep_truth     (dep_update0_dep_truth)
    );

    typedef struct {
        string       name;
        logic        rst;
        logic        req;
        logic [31:0] pc;
        logic [8:0]  asid;
        logic        upd;
        logic [31:0] upc;
        logic [8:0]  uasid;
        logic        truth;
        logic [7:0]  exp;
    } vec_t;

    vec_t vecs[$];
    int   mdl [512][8];
    int   n_vec = 0;
    int   n_bad = 0;

`ifdef MDPT_ASID_HASH_EN
    localparam logic [7:0] HASH_EXP = 8'h01;
`else
    localparam logic [7:0] HASH_EXP = 8'h00;
`endif

    function automatic vec_t mk(string name, logic rst, logic req, logic [31:0] pc, logic [8:0] asid,
                                logic upd, logic [31:0] upc, logic [8:0] uasid, logic truth,
                                logic [7:0] exp);
        vec_t v;
        v.name = name; v.rst = rst; v.req = req; v.pc = pc; v.asid = asid;
        v.upd = upd; v.upc = upc; v.uasid = uasid; v.truth = truth; v.exp = exp;
        return v;
    endfunction

    function automatic int set_of(logic [31:0] pc, logic [8:0] asid);
        int i;
        i = int'((pc >> 4) & 32'h1ff);
`ifdef MDPT_ASID_HASH_EN
        i = i ^ int'(asid);
`else
        if (asid == 9'h1ff) i = i;
`endif
        return i;
    endfunction

    // Reference: lookup sees counters as they were before this edge, then the update applies
    function automatic logic [7:0] model_step(vec_t v);
        logic [7:0] r;
        int s, k;
        r = 8'h00;
        if (v.rst) begin
            for (int a = 0; a < 512; a++)
                for (int b = 0; b < 8; b++) mdl[a][b] = 0;
            return r;
        end
        if (v.req) begin
            s = set_of(v.pc, v.asid);
            for (int b = 0; b < 8; b++) r[b] = (mdl[s][b] >= 2);
        end
        if (v.upd) begin
            s = set_of(v.upc, v.uasid);
            k = int'((v.upc >> 1) & 32'h7);
            if (v.truth) mdl[s][k] = (mdl[s][k] < 3) ? mdl[s][k] + 1 : 3;
            else         mdl[s][k] = (mdl[s][k] > 0) ? mdl[s][k] - 1 : 0;
        end
        return r;
    endfunction

    task automatic apply(input vec_t v, output logic [7:0] mexp);
        nRST                      = !v.rst;
        valid_REQ                 = v.req;
        full_PC_REQ               = v.pc;
        ASID_REQ                  = v.asid;
        dep_update0_valid         = v.upd;
        dep_update0_start_full_PC = v.upc;
        dep_update0_ASID          = v.uasid;
        dep_update0_dep_truth     = v.truth;
        mexp = model_step(v);
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: RESP got %02h expected %02h", name, got, want);
        end
    endtask

    initial begin
        logic [7:0] mexp;
        vec_t v;
        logic [31:0] r32;

        vecs.push_back(mk("reset",        1, 0, 32'h0,         0, 0, 32'h0,         0, 0, 8'h00));
        vecs.push_back(mk("idle",         0, 0, 32'h0,         0, 0, 32'h0,         0, 0, 8'h00));
        vecs.push_back(mk("cold",         0, 1, 32'h0000_1230, 0, 0, 32'h0,         0, 0, 8'h00));
        vecs.push_back(mk("train1",       0, 0, 32'h0,         0, 1, 32'h0000_1236, 0, 1, 8'h00));
        vecs.push_back(mk("train2",       0, 0, 32'h0,         0, 1, 32'h0000_1237, 0, 1, 8'h00));
        vecs.push_back(mk("trained",      0, 1, 32'h0000_1230, 0, 0, 32'h0,         0, 0, 8'h08));
        vecs.push_back(mk("alias_hi",     0, 1, 32'hFFFF_F231, 0, 0, 32'h0,         0, 0, 8'h08));
        vecs.push_back(mk("neighbour",    0, 1, 32'h0000_1220, 0, 0, 32'h0,         0, 0, 8'h00));
        vecs.push_back(mk("idle_after",   0, 0, 32'h0000_1230, 0, 0, 32'h0,         0, 0, 8'h00));
        vecs.push_back(mk("untrain1",     0, 0, 32'h0,         0, 1, 32'h0000_1236, 0, 0, 8'h00));
        vecs.push_back(mk("weak",         0, 1, 32'h0000_1230, 0, 0, 32'h0,         0, 0, 8'h00));
        vecs.push_back(mk("untrain2",     0, 0, 32'h0,         0, 1, 32'h0000_1236, 0, 0, 8'h00));
        vecs.push_back(mk("untrained",    0, 1, 32'h0000_1230, 0, 0, 32'h0,         0, 0, 8'h00));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk("sat_up",   0, 0, 32'h0,         0, 1, 32'h0000_0500, 0, 1, 8'h00));
        vecs.push_back(mk("sat_top",      0, 1, 32'h0000_0500, 0, 0, 32'h0,         0, 0, 8'h01));
        vecs.push_back(mk("sat_dn1",      0, 0, 32'h0,         0, 1, 32'h0000_0500, 0, 0, 8'h00));
        vecs.push_back(mk("sat_after1",   0, 1, 32'h0000_0500, 0, 0, 32'h0,         0, 0, 8'h01));
        vecs.push_back(mk("sat_dn2",      0, 0, 32'h0,         0, 1, 32'h0000_0500, 0, 0, 8'h00));
        vecs.push_back(mk("sat_after2",   0, 1, 32'h0000_0500, 0, 0, 32'h0,         0, 0, 8'h00));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk("floor_dn", 0, 0, 32'h0,         0, 1, 32'h0000_0500, 0, 0, 8'h00));
        vecs.push_back(mk("floor_up1",    0, 0, 32'h0,         0, 1, 32'h0000_0500, 0, 1, 8'h00));
        vecs.push_back(mk("floor_chk1",   0, 1, 32'h0000_0500, 0, 0, 32'h0,         0, 0, 8'h00));
        vecs.push_back(mk("floor_up2",    0, 0, 32'h0,         0, 1, 32'h0000_0500, 0, 1, 8'h00));
        vecs.push_back(mk("floor_chk2",   0, 1, 32'h0000_0500, 0, 0, 32'h0,         0, 0, 8'h01));
        vecs.push_back(mk("same_pre",     0, 0, 32'h0,         0, 1, 32'h0000_0704, 0, 1, 8'h00));
        vecs.push_back(mk("same_cycle",   0, 1, 32'h0000_0700, 0, 1, 32'h0000_0704, 0, 1, 8'h00));
        vecs.push_back(mk("same_next",    0, 1, 32'h0000_0700, 0, 0, 32'h0,         0, 0, 8'h04));
        vecs.push_back(mk("rst_prio",     1, 1, 32'h0000_0700, 0, 1, 32'h0000_0704, 0, 1, 8'h00));
        vecs.push_back(mk("rst_cleared",  0, 1, 32'h0000_0700, 0, 0, 32'h0,         0, 0, 8'h00));
        vecs.push_back(mk("rst_cleared2", 0, 1, 32'h0000_1230, 0, 0, 32'h0,         0, 0, 8'h00));
        vecs.push_back(mk("hash_train1",  0, 0, 32'h0,         0, 1, 32'h0000_0010, 1, 1, 8'h00));
        vecs.push_back(mk("hash_train2",  0, 0, 32'h0,         0, 1, 32'h0000_0010, 1, 1, 8'h00));
        vecs.push_back(mk("hash_lookup",  0, 1, 32'h0000_0000, 0, 0, 32'h0,         0, 0, HASH_EXP));

        foreach (vecs[i]) begin
            apply(vecs[i], mexp);
            check(vecs[i].name, dep_pred_by_instr_RESP, vecs[i].exp);
        end

        for (int n = 0; n < 1500; n++) begin
            v.name  = "random";
            v.rst   = ($urandom_range(0, 199) == 0);
            v.req   = 1'($urandom_range(0, 1));
            r32     = $urandom();
            r32[12:4] = 9'($urandom_range(0, 3));
            v.pc    = r32;
            v.asid  = 9'($urandom_range(0, 3));
            v.upd   = ($urandom_range(0, 9) < 7);
            r32     = $urandom();
            r32[12:4] = 9'($urandom_range(0, 3));
            v.upc   = r32;
            v.uasid = 9'($urandom_range(0, 3));
            v.truth = 1'($urandom_range(0, 1));
            v.exp   = 8'h00;
            apply(v, mexp);
            check("random", dep_pred_by_instr_RESP, mexp);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
